cfg_req_arb: RTL

- Round-robin arbiter and sequencer that shares one 32-bit config register bus among NUM_REQ requesters (sideband bridge, debug port, fuse puller, etc.).
- Accepts one request at a time, issues it on the bus as a single-cycle valid pulse, and waits for the matching read or write ack.
- Returns data and status to the winning requester; an ack that never arrives is reported as a timeout.
- Sits between the requester agents and the generated register-file request/ack ports.

---
 rtl/cfg_req_arb_if.sv | 57 +++++
 rtl/cfg_req_arb.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cfg_req_arb_if.sv
// Requester and config-bus handshake bundle for cfg_req_arb.
// The arbiter takes the slave view; requester agents / the register file take the master view.
interface cfg_req_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*4-1:0]  req_opcode;
  logic [NUM_REQ*48-1:0] req_addr;
  logic [NUM_REQ*4-1:0]  req_be;
  logic [NUM_REQ*32-1:0] req_data;
  logic [NUM_REQ*8-1:0]  req_sai;
  logic [NUM_REQ*8-1:0]  req_fid;
  logic [NUM_REQ*3-1:0]  req_bar;

  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;
  logic                  rsp_miss;
  logic                  rsp_sai_ok;
  logic                  rsp_timeout;

  logic                  cfg_req_valid;
  logic [3:0]            cfg_req_opcode;
  logic [47:0]           cfg_req_addr;
  logic [3:0]            cfg_req_be;
  logic [31:0]           cfg_req_data;
  logic [7:0]            cfg_req_sai;
  logic [7:0]            cfg_req_fid;
  logic [2:0]            cfg_req_bar;

  logic                  cfg_ack_read_valid;
  logic                  cfg_ack_read_miss;
  logic                  cfg_ack_write_valid;
  logic                  cfg_ack_write_miss;
  logic                  cfg_ack_sai_successfull;
  logic [31:0]           cfg_ack_data;

  logic                  busy;

  modport slave (
    input  req_valid, req_opcode, req_addr, req_be, req_data, req_sai, req_fid, req_bar,
    input  cfg_ack_read_valid, cfg_ack_read_miss, cfg_ack_write_valid, cfg_ack_write_miss,
    input  cfg_ack_sai_successfull, cfg_ack_data,
    output req_ready, rsp_valid, rsp_data, rsp_miss, rsp_sai_ok, rsp_timeout,
    output cfg_req_valid, cfg_req_opcode, cfg_req_addr, cfg_req_be, cfg_req_data,
    output cfg_req_sai, cfg_req_fid, cfg_req_bar, busy
  );

  modport master (
    output req_valid, req_opcode, req_addr, req_be, req_data, req_sai, req_fid, req_bar,
    output cfg_ack_read_valid, cfg_ack_read_miss, cfg_ack_write_valid, cfg_ack_write_miss,
    output cfg_ack_sai_successfull, cfg_ack_data,
    input  req_ready, rsp_valid, rsp_data, rsp_miss, rsp_sai_ok, rsp_timeout,
    input  cfg_req_valid, cfg_req_opcode, cfg_req_addr, cfg_req_be, cfg_req_data,
    input  cfg_req_sai, cfg_req_fid, cfg_req_bar, busy
  );
endinterface

// File: rtl/cfg_req_arb.sv
// Round-robin arbiter/sequencer sharing one config register bus among NUM_REQ requesters,
// one transaction at a time, with ack timeout.
module cfg_req_arb #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  cfg_req_arb_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [47:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  sai;
    logic [7:0]  fid;
    logic [2:0]  bar;
  } req_t;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  req_t               req_q, req_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               miss_q, miss_d;
  logic               sai_q, sai_d;
  logic               to_q, to_d;

  logic               found;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] req_ready_c;

  // First valid requester after the pointer, with wrap.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    miss_d      = miss_q;
    sai_d       = sai_q;
    to_d        = to_q;
    req_ready_c = '0;
    case (state_q)
      IDLE: if (found) begin
        req_ready_c[gnt_idx] = 1'b1;
        ptr_d        = gnt_idx;
        gnt_d        = gnt_idx;
        req_d.opcode = bus.req_opcode[int'(gnt_idx)*4 +: 4];
        req_d.addr   = bus.req_addr[int'(gnt_idx)*48 +: 48];
        req_d.be     = bus.req_be[int'(gnt_idx)*4 +: 4];
        req_d.data   = bus.req_data[int'(gnt_idx)*32 +: 32];
        req_d.sai    = bus.req_sai[int'(gnt_idx)*8 +: 8];
        req_d.fid    = bus.req_fid[int'(gnt_idx)*8 +: 8];
        req_d.bar    = bus.req_bar[int'(gnt_idx)*3 +: 3];
        // Opcodes 8..15 never reach the bus; answer straight away with a miss.
        if (req_d.opcode[3]) begin
          state_d = RESP;
          rdata_d = '0;
          miss_d  = 1'b1;
          sai_d   = 1'b0;
          to_d    = 1'b0;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Odd opcodes are writes; an ack of the other type does not stop the count.
        if (!req_q.opcode[0] && bus.cfg_ack_read_valid) begin
          rdata_d = bus.cfg_ack_data;
          miss_d  = bus.cfg_ack_read_miss;
          sai_d   = bus.cfg_ack_sai_successfull;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (req_q.opcode[0] && bus.cfg_ack_write_valid) begin
          rdata_d = '0;
          miss_d  = bus.cfg_ack_write_miss;
          sai_d   = bus.cfg_ack_sai_successfull;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_W'(TIMEOUT-1)) begin
          rdata_d = '0;
          miss_d  = 1'b1;
          sai_d   = 1'b0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A grant during reset would be lost, so never signal one.
    if (!rst_n) req_ready_c = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(NUM_REQ-1);
      gnt_q   <= '0;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      miss_q  <= 1'b0;
      sai_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      miss_q  <= miss_d;
      sai_q   <= sai_d;
      to_q    <= to_d;
    end
  end

  assign bus.req_ready      = req_ready_c;
  assign bus.rsp_valid      = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign bus.rsp_data       = (state_q == RESP) ? rdata_q : '0;
  assign bus.rsp_miss       = (state_q == RESP) && miss_q;
  assign bus.rsp_sai_ok     = (state_q == RESP) && sai_q;
  assign bus.rsp_timeout    = (state_q == RESP) && to_q;
  assign bus.cfg_req_valid  = (state_q == ISSUE);
  assign bus.cfg_req_opcode = req_q.opcode;
  assign bus.cfg_req_addr   = req_q.addr;
  assign bus.cfg_req_be     = req_q.be;
  assign bus.cfg_req_data   = req_q.data;
  assign bus.cfg_req_sai    = req_q.sai;
  assign bus.cfg_req_fid    = req_q.fid;
  assign bus.cfg_req_bar    = req_q.bar;
  assign bus.busy           = (state_q != IDLE);
endmodule
